// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control unit: Moore FSM sequencing fetch/decode/execute,
// with a sticky illegal-instruction flag and a wrapping retired-instruction counter.
module mc_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        iord,
   output logic        memwrite,
   output logic        irwrite,
   output logic        pcen,
   output logic [1:0]  pcsrc,
   output logic        alusrca,
   output logic [1:0]  alusrcb,
   output logic [2:0]  alucontrol,
   output logic        regdst,
   output logic        memtoreg,
   output logic        regwrite,
   output logic        retire,
   output logic        illegal,
   output logic [15:0] instr_count,
   output logic [3:0]  state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEXEC = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t      state_q, state_d;
   logic        illegal_q, illegal_d;
   logic [15:0] instr_count_q, instr_count_d;

   // Returns {supported, alu op}; unsupported functs fall back to add.
   function automatic logic [3:0] funct_decode(input logic [5:0] f);
      logic [3:0] r;
      case (f)
         6'b100000: r = {1'b1, ALU_ADD};
         6'b100010: r = {1'b1, ALU_SUB};
         6'b100100: r = {1'b1, ALU_AND};
         6'b100101: r = {1'b1, ALU_OR};
         6'b101010: r = {1'b1, ALU_SLT};
         default:   r = {1'b0, ALU_ADD};
      endcase
      return r;
   endfunction

   // Next-state, Moore outputs (plus the mem_ready/zero handshake terms) and counter update.
   always_comb begin
      logic [3:0] fd;
      fd            = funct_decode(funct);
      state_d       = state_q;
      illegal_d     = illegal_q;
      iord          = 1'b0;
      memwrite      = 1'b0;
      irwrite       = 1'b0;
      pcen          = 1'b0;
      pcsrc         = 2'b00;
      alusrca       = 1'b0;
      alusrcb       = 2'b00;
      alucontrol    = ALU_ADD;
      regdst        = 1'b0;
      memtoreg      = 1'b0;
      regwrite      = 1'b0;
      retire        = 1'b0;
      case (state_q)
         S_FETCH: begin
            alusrcb = 2'b01;
            if (mem_ready) begin
               irwrite = 1'b1;
               pcen    = 1'b1;
               state_d = S_DECODE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTEXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default: begin
                  state_d   = S_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            if (op == OP_LW) begin
               state_d = S_MEMRD;
            end else begin
               state_d = S_MEMWR;
            end
         end
         S_MEMRD: begin
            iord = 1'b1;
            if (mem_ready) begin
               state_d = S_MEMWB;
            end else begin
               state_d = S_MEMRD;
            end
         end
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_MEMWR;
            end
         end
         S_RTEXEC: begin
            alusrca    = 1'b1;
            alucontrol = fd[2:0];
            if (fd[3]) begin
               state_d = S_ALUWB;
            end else begin
               state_d   = S_FETCH;
               illegal_d = 1'b1;
            end
         end
         S_ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            alusrca    = 1'b1;
            alucontrol = ALU_SUB;
            pcsrc      = 2'b01;
            pcen       = zero;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_JUMP: begin
            pcsrc   = 2'b10;
            pcen    = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      if (retire) begin
         instr_count_d = instr_count_q + 16'd1;
      end else begin
         instr_count_d = instr_count_q;
      end
   end

   // State, sticky illegal flag and retire counter; reset overrides any transition.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_FETCH;
         illegal_q     <= 1'b0;
         instr_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         illegal_q     <= illegal_d;
         instr_count_q <= instr_count_d;
      end
   end

   assign state       = state_q;
   assign illegal     = illegal_q;
   assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: an instruction-level model emits the expected
// per-cycle output record; a negedge monitor pops and compares against the DUT.
module tb_mc_controller;

   logic        clk;
   logic        reset;
   logic [5:0]  op_i, funct_i;
   logic        zero_i, mem_ready;
   logic        iord, memwrite, irwrite, pcen, alusrca, regdst, memtoreg, regwrite;
   logic        retire, illegal;
   logic [1:0]  pcsrc, alusrcb;
   logic [2:0]  alucontrol;
   logic [15:0] instr_count;
   logic [3:0]  state;

   typedef struct packed {
      logic [3:0]  st;
      logic        iord, memwrite, irwrite, pcen;
      logic [1:0]  pcsrc;
      logic        alusrca;
      logic [1:0]  alusrcb;
      logic [2:0]  aluc;
      logic        regdst, memtoreg, regwrite, retire, illegal;
      logic [15:0] cnt;
   } obs_t;

   obs_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_cnt  = 16'd0;
   logic        exp_ill  = 1'b0;

   mc_controller dut (
      .clk(clk), .reset(reset), .op(op_i), .funct(funct_i), .zero(zero_i),
      .mem_ready(mem_ready), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
      .pcen(pcen), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
      .alucontrol(alucontrol), .regdst(regdst), .memtoreg(memtoreg),
      .regwrite(regwrite), .retire(retire), .illegal(illegal),
      .instr_count(instr_count), .state(state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected outputs for one cycle of a given state, straight from the control table.
   function automatic obs_t spec_out(input int st, input logic [5:0] fn, input logic z, input logic mr);
      obs_t e;
      e      = '0;
      e.st   = st[3:0];
      e.aluc = 3'b010;
      case (st)
         0: begin e.alusrcb = 2'd1; e.irwrite = mr; e.pcen = mr; end
         1: e.alusrcb = 2'd3;
         2: begin e.alusrca = 1'b1; e.alusrcb = 2'd2; end
         3: e.iord = 1'b1;
         4: begin e.memtoreg = 1'b1; e.regwrite = 1'b1; e.retire = 1'b1; end
         5: begin e.iord = 1'b1; e.memwrite = 1'b1; e.retire = mr; end
         6: begin
            e.alusrca = 1'b1;
            case (fn)
               6'b100010: e.aluc = 3'b110;
               6'b100100: e.aluc = 3'b000;
               6'b100101: e.aluc = 3'b001;
               6'b101010: e.aluc = 3'b111;
               default:   e.aluc = 3'b010;
            endcase
         end
         7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; e.retire = 1'b1; end
         8:  begin e.alusrca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'd1; e.pcen = z; e.retire = 1'b1; end
         9:  begin e.alusrca = 1'b1; e.alusrcb = 2'd2; end
         10: begin e.regwrite = 1'b1; e.retire = 1'b1; end
         11: begin e.pcsrc = 2'd2; e.pcen = 1'b1; e.retire = 1'b1; end
         default: e.st = 4'd0;
      endcase
      return e;
   endfunction

   function automatic logic funct_ok(input logic [5:0] fn);
      return (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) ||
             (fn == 6'b100101) || (fn == 6'b101010);
   endfunction

   // Called at posedge+1: drive this cycle's inputs, queue the expectation, advance one cycle.
   task automatic cyc(input int st, input logic mr, input logic rst);
      obs_t e;
      mem_ready = mr;
      reset     = rst;
      e         = spec_out(st, funct_i, zero_i, mr);
      e.illegal = exp_ill;
      e.cnt     = exp_cnt;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (rst) begin
         exp_cnt = 16'd0;
         exp_ill = 1'b0;
      end else if (e.retire) begin
         exp_cnt = exp_cnt + 16'd1;
      end
   endtask

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   // One whole instruction: fw/mw are the memory wait states in FETCH and MEMRD/MEMWR.
   task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input int fw, input int mw);
      op_i = op; funct_i = fn; zero_i = z;
      for (int i = 0; i < fw; i++) cyc(0, 1'b0, 1'b0);
      cyc(0, 1'b1, 1'b0);
      cyc(1, rnd_bit(), 1'b0);
      case (op)
         6'b100011: begin
            cyc(2, rnd_bit(), 1'b0);
            for (int i = 0; i < mw; i++) cyc(3, 1'b0, 1'b0);
            cyc(3, 1'b1, 1'b0);
            cyc(4, rnd_bit(), 1'b0);
         end
         6'b101011: begin
            cyc(2, rnd_bit(), 1'b0);
            for (int i = 0; i < mw; i++) cyc(5, 1'b0, 1'b0);
            cyc(5, 1'b1, 1'b0);
         end
         6'b000000: begin
            cyc(6, rnd_bit(), 1'b0);
            if (funct_ok(fn)) cyc(7, rnd_bit(), 1'b0);
            else exp_ill = 1'b1;
         end
         6'b000100: cyc(8, rnd_bit(), 1'b0);
         6'b001000: begin
            cyc(9, rnd_bit(), 1'b0);
            cyc(10, rnd_bit(), 1'b0);
         end
         6'b000010: cyc(11, rnd_bit(), 1'b0);
         default: exp_ill = 1'b1;
      endcase
   endtask

   task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Monitor: every cycle with a pending expectation is compared in full.
   always @(negedge clk) begin
      obs_t e, g;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         g = {state, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb, alucontrol,
              regdst, memtoreg, regwrite, retire, illegal, instr_count};
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL trace st=%0d t=%0t: got %h expected %h", e.st, $time, g, e);
         end
      end
   end

   initial begin
      logic [5:0] ops [7];
      logic [5:0] fns [6];
      logic [5:0] o, f;
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
      op_i = 6'd0; funct_i = 6'd0; zero_i = 1'b0; mem_ready = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;

      issue(6'b100011, 6'd0, 1'b0, 1, 0);        // first cycle after reset: FETCH, mem_ready=0
      issue(6'b100011, 6'd0, 1'b0, 0, 0);        // LW, no waits: 0,1,2,3,4
      issue(6'b101011, 6'd0, 1'b0, 0, 3);        // SW with 3 write wait states
      issue(6'b000100, 6'd0, 1'b1, 0, 0);        // BEQ taken
      issue(6'b000100, 6'd0, 1'b0, 0, 0);        // BEQ not taken
      issue(6'b000000, 6'b101010, 1'b0, 0, 0);   // slt
      issue(6'b001000, 6'd0, 1'b0, 0, 0);
      issue(6'b000010, 6'd0, 1'b0, 0, 0);
      issue(6'b000000, 6'b111111, 1'b0, 0, 0);   // bad funct -> illegal
      issue(6'b111111, 6'd0, 1'b0, 0, 0);        // bad op
      check16("illegal_sticky", {15'd0, illegal}, 16'd1);

      for (int n = 0; n < 80; n++) begin
         o = ops[$urandom_range(0, 6)];
         if ($urandom_range(0, 9) == 0) o = 6'($urandom_range(0, 63));
         f = fns[$urandom_range(0, 5)];
         if ($urandom_range(0, 4) == 0) f = 6'($urandom_range(0, 63));
         issue(o, f, rnd_bit(), $urandom_range(0, 2), $urandom_range(0, 2));
      end

      // Reset while waiting in MEMRD, mem_ready then held high.
      op_i = 6'b100011;
      cyc(0, 1'b1, 1'b0);
      cyc(1, 1'b1, 1'b0);
      cyc(2, 1'b1, 1'b0);
      cyc(3, 1'b0, 1'b0);
      cyc(3, 1'b1, 1'b1);
      check16("rst_count", instr_count, 16'd0);
      check16("rst_illegal", {15'd0, illegal}, 16'd0);
      issue(6'b100011, 6'd0, 1'b0, 0, 0);

      // Back-to-back jumps until the counter wraps to zero.
      reset = 1'b1; mem_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0; exp_cnt = 16'd0; exp_ill = 1'b0;
      for (int n = 0; n < 65536; n++) issue(6'b000010, 6'd0, 1'b0, 0, 0);
      check16("wrap_count", instr_count, 16'd0);
      check16("wrap_illegal", {15'd0, illegal}, 16'd0);

      @(negedge clk); #1;
      check16("sb_drained", 16'(sb_q.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have the following ports:
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  6  instruction opcode, from the instruction register.
- funct  in  6  R-type function field.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register load.
- pcen  out  1  PC load enable.
- pcsrc  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- alusrca  out  1  ALU A select: 0=PC, 1=register A.
- alusrcb  out  2  ALU B select: 00=register B, 01=constant 4, 10=sign-extended immediate, 11=immediate shifted left by 2.
- alucontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- regdst  out  1  register write destination: 0=rt, 1=rd.
- memtoreg  out  1  register write data: 0=ALUOut, 1=memory data.
- regwrite  out  1  register file write enable.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  sticky flag: an unsupported op or funct was decoded.
- instr_count  out  16  count of retired instructions.
- state  out  4  current FSM state, for debug.

Function
REQ-002 The block SHALL be a Moore FSM with the following 4-bit state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH on the next cycle.
REQ-003 Default output values SHALL apply in every state unless overridden: all 1-bit outputs 0, pcsrc=00, alusrcb=00, alucontrol=010.
REQ-004 FETCH SHALL drive iord=0, alusrca=0, alusrcb=01 and add.
- If mem_ready=1: irwrite=1 and pcen=1, then go to DECODE.
- If mem_ready=0: irwrite=0 and pcen=0, and stay in FETCH.
REQ-005 DECODE SHALL drive alusrca=0, alusrcb=11 and add, then branch on op:
- 100011 (LW) or 101011 (SW) -> MEMADR.
- 000000 (R-type) -> RTEXEC.
- 000100 (BEQ) -> BRANCH.
- 001000 (ADDI) -> ADDIEX.
- 000010 (J) -> JUMP.
- Any other op -> FETCH, and set illegal.
REQ-006 MEMADR SHALL drive alusrca=1, alusrcb=10 and add, then go to MEMRD for LW or MEMWR for SW.
REQ-007 MEMRD SHALL drive iord=1 and go to MEMWB only when mem_ready=1; otherwise it stays in MEMRD.
REQ-008 MEMWB SHALL drive regdst=0, memtoreg=1 and regwrite=1, then go to FETCH.
REQ-009 MEMWR SHALL hold iord=1 and memwrite=1 on every cycle of the state, and go to FETCH only when mem_ready=1.
REQ-010 RTEXEC SHALL drive alusrca=1 and alusrcb=00, and set alucontrol from funct:
- 100000 -> 010 (add).
- 100010 -> 110 (sub).
- 100100 -> 000 (and).
- 100101 -> 001 (or).
- 101010 -> 111 (slt).
- Any other funct: alucontrol=010, set illegal, and go to FETCH without entering ALUWB.
- Supported funct: go to ALUWB.
REQ-011 ALUWB SHALL drive regdst=1, memtoreg=0 and regwrite=1, then go to FETCH.
REQ-012 BRANCH SHALL drive alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01 and pcen=zero (a combinational term), then go to FETCH.
REQ-013 ADDIEX SHALL drive alusrca=1, alusrcb=10 and add, then go to ADDIWB.
REQ-014 ADDIWB SHALL drive regdst=0, memtoreg=0 and regwrite=1, then go to FETCH.
REQ-015 JUMP SHALL drive pcsrc=10 and pcen=1, then go to FETCH.
REQ-016 retire SHALL be 1 in the following cases:
- MEMWB, ALUWB, ADDIWB, BRANCH and JUMP.
- MEMWR in the cycle where mem_ready=1.
- retire SHALL NOT assert for instructions dropped as illegal.
REQ-017 instr_count SHALL increment by 1 on each clock edge where retire=1, and SHALL wrap from 0xFFFF to 0x0000.
REQ-018 illegal SHALL stay at 1 once set, and SHALL clear only on reset.
REQ-019 Latency per instruction, counting cycles from FETCH through retire, with zero memory wait states:
- LW: 5 cycles.
- SW: 4 cycles.
- R-type: 4 cycles.
- ADDI: 4 cycles.
- BEQ: 3 cycles.
- J: 3 cycles.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.

Reset
REQ-020 When reset=1 at a clock edge, the block SHALL set state=FETCH, instr_count=0 and illegal=0, and this SHALL take priority over every transition, including a reset arriving in the middle of an instruction.
REQ-021 In the cycle after reset, all outputs SHALL equal the FETCH values with mem_ready=0 (pcen=0, irwrite=0, memwrite=0, regwrite=0).

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- LW (op=100011), mem_ready=1 always -> states 0,1,2,3,4 in order; regwrite=1 and memtoreg=1 in the 5th cycle; instr_count=1.
- SW (op=101011), mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles; retire asserts once, in the final cycle.
- BEQ (op=000100) with zero=1, and again with zero=0 -> pcen=1 with pcsrc=01 in the first case; pcen=0 in the second; both retire.
- R-type with funct=101010, then funct=111111 -> alucontrol=111 followed by ALUWB for the first; illegal=1 and no regwrite for the second, with a return to FETCH.
- Reset asserted while in MEMRD -> state=0, instr_count=0, illegal=0 on the next cycle; a held mem_ready produces no spurious regwrite.
- 65536 back-to-back J instructions -> instr_count wraps to 0; illegal stays 0.
